// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the hazard controller: FSM encoding, pipeline control bundle
// and the freeze patterns used by both RUN entry and the wait states.
package hazard_ctrl_pkg;

   typedef enum logic [1:0] {
      RUN       = 2'd0,
      DMEM_WAIT = 2'd1,
      MD_BUSY   = 2'd2
   } state_e;

   localparam logic [4:0] REG_ZERO = 5'd0;

   typedef struct packed {
      logic pc_stall;
      logic if_id_stall;
      logic if_id_flush;
      logic id_ex_stall;
      logic id_ex_flush;
      logic ex_mem_stall;
      logic mem_wb_flush;
      logic md_err;
   } ctrl_t;

   // A pending data access holds IF..EX and drains a bubble into WB.
   function automatic ctrl_t dmem_freeze();
      ctrl_t c;
      c              = '0;
      c.pc_stall     = 1'b1;
      c.if_id_stall  = 1'b1;
      c.id_ex_stall  = 1'b1;
      c.ex_mem_stall = 1'b1;
      c.mem_wb_flush = 1'b1;
      return c;
   endfunction

   function automatic ctrl_t md_freeze();
      ctrl_t c;
      c              = '0;
      c.pc_stall     = 1'b1;
      c.if_id_stall  = 1'b1;
      c.id_ex_stall  = 1'b1;
      c.ex_mem_stall = 1'b1;
      return c;
   endfunction

endpackage

// File: rtl/hazard_ctrl_lu_detect.sv
// Load-use comparator: flags an ID-stage source that depends on a load in EX.
module hazard_ctrl_lu_detect
   import hazard_ctrl_pkg::*;
(
   input  logic       ex_mem_read,
   input  logic [4:0] ex_rd,
   input  logic [4:0] id_rs1,
   input  logic [4:0] id_rs2,
   input  logic       id_use_rs1,
   input  logic       id_use_rs2,
   output logic       lu_hit
);

   logic rs1_match;
   logic rs2_match;

   assign rs1_match = id_use_rs1 && (id_rs1 == ex_rd);
   assign rs2_match = id_use_rs2 && (id_rs2 == ex_rd);
   // x0 is hardwired zero, so a load targeting it never creates a dependency.
   assign lu_hit    = ex_mem_read && (ex_rd != REG_ZERO) && (rs1_match || rs2_match);

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline with DMEM and mul/div freeze FSM.
// Optional macro HAZARD_CTRL_PERF_EN adds saturating stall/flush cycle counters.
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int MD_TIMEOUT = 64,
   parameter int CNT_W      = 7
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  id_rs1,
   input  logic [4:0]  id_rs2,
   input  logic        id_use_rs1,
   input  logic        id_use_rs2,
   input  logic [4:0]  ex_rd,
   input  logic        ex_mem_read,
   input  logic        ex_redirect,
   input  logic        ex_md_start,
   input  logic        md_done,
   input  logic        mem_req,
   input  logic        dmem_ready,
   input  logic        imem_ready,
   output logic        pc_stall,
   output logic        if_id_stall,
   output logic        if_id_flush,
   output logic        id_ex_stall,
   output logic        id_ex_flush,
   output logic        ex_mem_stall,
   output logic        mem_wb_flush,
   output logic        md_err
`ifdef HAZARD_CTRL_PERF_EN
   ,
   output logic [31:0] perf_stall_cnt,
   output logic [31:0] perf_flush_cnt
`endif
);

   localparam logic [CNT_W-1:0] MD_LAST = CNT_W'(MD_TIMEOUT - 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   ctrl_t            ctrl;
   ctrl_t            ctrl_out;
   logic             lu_hit;

   hazard_ctrl_lu_detect u_lu_detect (
      .ex_mem_read (ex_mem_read),
      .ex_rd       (ex_rd),
      .id_rs1      (id_rs1),
      .id_rs2      (id_rs2),
      .id_use_rs1  (id_use_rs1),
      .id_use_rs2  (id_use_rs2),
      .lu_hit      (lu_hit)
   );

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values regardless of process ordering.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= RUN;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // NOTE: every signal written here gets a default first, so no path leaves
   // one unassigned and no latch is inferred.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ctrl    = '0;
      unique case (state_q)
         RUN: begin
            if (mem_req && !dmem_ready) begin
               ctrl    = dmem_freeze();
               state_d = DMEM_WAIT;
            end else if (ex_md_start && !md_done) begin
               ctrl    = md_freeze();
               state_d = MD_BUSY;
               cnt_d   = '0;
            end else if (ex_redirect) begin
               // PC keeps running so it can load the branch target.
               ctrl.if_id_flush = 1'b1;
               ctrl.id_ex_flush = 1'b1;
            end else begin
               if (lu_hit) begin
                  ctrl.pc_stall    = 1'b1;
                  ctrl.if_id_stall = 1'b1;
                  ctrl.id_ex_flush = 1'b1;
               end
               if (!imem_ready) begin
                  ctrl.pc_stall    = 1'b1;
                  // Holding IF_ID for the load-use stall takes precedence over the fetch bubble.
                  ctrl.if_id_flush = !lu_hit;
               end
            end
         end
         DMEM_WAIT: begin
            if (dmem_ready) begin
               state_d = RUN;
            end else begin
               ctrl = dmem_freeze();
            end
         end
         MD_BUSY: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (md_done) begin
               state_d = RUN;
            end else if (cnt_q == MD_LAST) begin
               ctrl.md_err = 1'b1;
               state_d     = RUN;
            end else begin
               ctrl = md_freeze();
            end
         end
         default: state_d = RUN;
      endcase
   end

   assign ctrl_out     = rst ? '0 : ctrl;
   assign pc_stall     = ctrl_out.pc_stall;
   assign if_id_stall  = ctrl_out.if_id_stall;
   assign if_id_flush  = ctrl_out.if_id_flush;
   assign id_ex_stall  = ctrl_out.id_ex_stall;
   assign id_ex_flush  = ctrl_out.id_ex_flush;
   assign ex_mem_stall = ctrl_out.ex_mem_stall;
   assign mem_wb_flush = ctrl_out.mem_wb_flush;
   assign md_err       = ctrl_out.md_err;

`ifdef HAZARD_CTRL_PERF_EN
   logic [31:0] perf_stall_q, perf_stall_d;
   logic [31:0] perf_flush_q, perf_flush_d;

   always_comb begin
      perf_stall_d = perf_stall_q;
      perf_flush_d = perf_flush_q;
      if (pc_stall && (perf_stall_q != '1)) perf_stall_d = perf_stall_q + 32'd1;
      if (if_id_flush && (perf_flush_q != '1)) perf_flush_d = perf_flush_q + 32'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_stall_q <= '0;
         perf_flush_q <= '0;
      end else begin
         perf_stall_q <= perf_stall_d;
         perf_flush_q <= perf_flush_d;
      end
   end

   assign perf_stall_cnt = perf_stall_q;
   assign perf_flush_cnt = perf_flush_q;
`endif

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage RISC-V pipeline. Drives the stall and flush inputs of IF_ID, ID_EX, EX_MEM and MEM_WB, plus the PC enable. Detects load-use hazards and EX-stage redirects. Runs an FSM that freezes the pipeline during multi-cycle data-memory accesses and multiply/divide operations.

Parameters:
MD_TIMEOUT, 64, max cycles in MD_BUSY before forced release and md_err pulse
CNT_W, 7, width of the internal busy-cycle counter; must satisfy 2^CNT_W > MD_TIMEOUT

Ports:
clk  input  1  pipeline clock, rising edge
rst  input  1  asynchronous, active-high reset
id_rs1  input  5  rs1 of the instruction in ID
id_rs2  input  5  rs2 of the instruction in ID
id_use_rs1  input  1  ID instruction reads rs1
id_use_rs2  input  1  ID instruction reads rs2
ex_rd  input  5  destination register of the instruction in EX
ex_mem_read  input  1  EX instruction is a load
ex_redirect  input  1  taken branch or jump resolved in EX
ex_md_start  input  1  EX instruction is a multi-cycle mul/div
md_done  input  1  mul/div result valid
mem_req  input  1  MEM stage issuing a data-memory access
dmem_ready  input  1  data memory completes the access this cycle
imem_ready  input  1  instruction fetch data valid this cycle
pc_stall  output  1  hold PC
if_id_stall  output  1  to IF_ID stall
if_id_flush  output  1  to IF_ID flush
id_ex_stall  output  1  hold ID_EX
id_ex_flush  output  1  bubble into ID_EX
ex_mem_stall  output  1  hold EX_MEM
mem_wb_flush  output  1  bubble into MEM_WB
md_err  output  1  one-cycle pulse on MD timeout

Behaviour:
- Single clock, clk. rst is asynchronous active-high.
- FSM states: RUN, DMEM_WAIT, MD_BUSY. State and counter are registered. All outputs are combinational from state and inputs (zero latency).
- On reset: state=RUN, counter=0, md_err=0. While rst=1, all outputs are forced 0.
- Reset asserted mid-operation: return to RUN immediately; no pending stall survives reset.
- Evaluation order in RUN, highest priority first:
  1. mem_req & !dmem_ready:
     - Assert pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_flush.
     - Next state DMEM_WAIT.
  2. ex_md_start & !md_done:
     - Assert pc_stall, if_id_stall, id_ex_stall, ex_mem_stall.
     - Next state MD_BUSY, counter=0.
  3. ex_redirect:
     - Assert if_id_flush and id_ex_flush.
     - PC is not stalled (it loads the target).
     - A load-use hit in the same cycle is ignored.
  4. Load-use hit, defined as ex_mem_read & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)):
     - Assert pc_stall, if_id_stall, id_ex_flush for exactly one cycle.
  5. !imem_ready:
     - Assert pc_stall and if_id_flush (bubble into ID).
     - May combine with 4: then if_id_stall wins and if_id_flush=0.
- DMEM_WAIT:
  - Same freeze outputs as RUN case 1.
  - On dmem_ready=1: outputs deassert in that cycle; next state RUN.
- MD_BUSY:
  - Same freeze outputs as RUN case 2; counter increments every cycle.
  - On md_done=1: release in that cycle; next state RUN.
  - Counter reaching MD_TIMEOUT-1 without md_done: release, pulse md_err for 1 cycle, next state RUN.
- ex_redirect, load-use and ex_md_start are ignored while in DMEM_WAIT or MD_BUSY (EX is frozen; they are re-seen on release).
- ex_md_start with md_done=1 in the same cycle: no stall, stay in RUN.
- Stall and flush to the same register are never both 1.

Optional Feature:
HAZARD_CTRL_PERF_EN
- Defined: adds outputs perf_stall_cnt[31:0] and perf_flush_cnt[31:0].
  - perf_stall_cnt counts cycles with pc_stall=1.
  - perf_flush_cnt counts cycles with if_id_flush=1.
  - Both saturate at 0xFFFFFFFF and reset to 0.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package: FSM state encoding (RUN=2'd0, DMEM_WAIT=2'd1, MD_BUSY=2'd2) and the REG_ZERO=5'd0 constant.
- One sub-module is natural: hazard_ctrl_lu_detect, a combinational load-use comparator.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd=5, id_rs1=5, id_use_rs1=1 -> pc_stall=if_id_stall=id_ex_flush=1 for 1 cycle, then 0.
- Load to x0: ex_rd=0, id_rs1=0 -> no stall.
- Redirect plus load-use in the same cycle -> if_id_flush=id_ex_flush=1, pc_stall=0.
- mem_req=1 with dmem_ready low for 3 cycles -> 3 cycles of full freeze with mem_wb_flush=1; released in the cycle dmem_ready=1.
- ex_md_start=1 with md_done held 0, MD_TIMEOUT=8 -> freeze for 8 cycles, md_err pulses once, state returns to RUN.
- Assert rst during DMEM_WAIT -> all outputs 0 immediately; after release, state is RUN.
